div_step_seq: RTL and testbench

- Sequencer and restore stage for the 16-bit bit-serial restoring divider.
- It sits around the shift-add sum stage. Each cycle it drives `count`, `en_sum` and the shifted partial remainder into the sum stage. It drives the latched dividend onto the sum stage's dividend input, and consumes the sum result on the same cycle.
- Each cycle it compares the sum result against the divisor, restores or subtracts, and shifts one quotient bit in.
- It owns the start/busy/done handshake toward the control FSM.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step_seq.sv | 131 +++++++++++++
 tb/tb_div_step_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the bit-serial restoring divider.
package div_pkg;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = 4'hF;
  localparam logic [DIV_W-1:0] DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_step_seq.sv
// Sequencer and restore stage of the 16-bit restoring divider: drives the
// external sum stage, restores/subtracts, and owns the start/busy/done handshake.
module div_step_seq #(
  parameter int unsigned WIDTH = div_pkg::DIV_W,
  parameter int unsigned CNT_W = div_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] dvd_q,
  output logic [WIDTH-1:0] sum_a,
  output logic [CNT_W-1:0] count,
  output logic             en_sum,
  input  logic [WIDTH-1:0] sum_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  import div_pkg::*;

  state_t           state, state_next;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_next;
  logic             sub_ok;
  logic             busy_d, done_d, en_sum_d;

  // rem[15] is always 0 in RUN, so dropping it here loses nothing
  assign sum_a = {rem[WIDTH-2:0], 1'b0};

  // Restoring step: subtract only when the partial remainder covers the divisor
  always_comb begin
    sub_ok   = (sum_in >= div_q);
    rem_next = sub_ok ? WIDTH'(sum_in - div_q) : sum_in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (count == LAST_STEP) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    en_sum_d = 1'b0;
    unique case (state_next)
      RUN: begin
        busy_d   = 1'b1;
        en_sum_d = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      en_sum <= 1'b0;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      en_sum <= en_sum_d;
    end
  end

  // Operand capture and per-step datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= '0;
      div_q     <= '0;
      rem       <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd_q    <= dividend;
            div_q    <= divisor;
            rem      <= '0;
            count    <= '0;
            quotient <= '0;
            div_zero <= 1'b0;
            if (divisor == '0) begin
              quotient  <= DIV0_QUOT;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem      <= rem_next;
          quotient <= {quotient[WIDTH-2:0], sub_ok};
          count    <= CNT_W'(count + 1'b1);
          if (count == LAST_STEP) remainder <= rem_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_step_seq.sv
// Bench for div_step_seq: models the sum stage beside the DUT and checks
// results against plain integer division.
module tb_div_step_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic [15:0] dvd_q, sum_a, sum_in;
  logic [3:0]  count;
  logic        en_sum, busy, done, div_zero;
  logic [15:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_step_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .dvd_q     (dvd_q),
    .sum_a     (sum_a),
    .count     (count),
    .en_sum    (en_sum),
    .sum_in    (sum_in),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // Sum stage: appends the selected dividend bit when enabled, else passes sum_a
  logic [3:0] bit_sel;
  assign bit_sel = 4'(4'd15 - count);
  assign sum_in  = en_sum ? 16'(sum_a + {15'd0, dvd_q[bit_sel]}) : sum_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One division; optionally pulses a second start at cycle inj_at with other operands
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input int inj_at, input logic [15:0] ia, input logic [15:0] ib);
    logic [15:0] exp_q, exp_r;
    int lat, ens, k;
    if (b == 16'd0) begin
      exp_q = 16'hFFFF;
      exp_r = a;
    end else begin
      exp_q = a / b;
      exp_r = a % b;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    lat = 0;
    ens = 0;
    k   = 0;
    for (int i = 1; i <= 40; i++) begin
      chk("busy", 32'(busy), 32'd1);
      if (en_sum) begin
        chk("count_seq", 32'(count), 32'(k));
        chk("rem15_zero", 32'(dut.rem[15]), 32'd0);
        ens++;
        k++;
      end
      if (done) begin
        lat = i;
        break;
      end
      if (i == inj_at) begin
        start    = 1'b1;
        dividend = ia;
        divisor  = ib;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("latency", 32'(lat), (b == 16'd0) ? 32'd1 : 32'd17);
    chk("en_sum_cycles", 32'(ens), (b == 16'd0) ? 32'd0 : 32'd16);
    chk("quotient", 32'(quotient), 32'(exp_q));
    chk("remainder", 32'(remainder), 32'(exp_r));
    chk("div_zero", 32'(div_zero), (b == 16'd0) ? 32'd1 : 32'd0);
    tick();
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("quotient_hold", 32'(quotient), 32'(exp_q));
    chk("remainder_hold", 32'(remainder), 32'(exp_r));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dvd_q"}, 32'(dvd_q), 32'd0);
    chk({tag, "_sum_a"}, 32'(sum_a), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_en_sum"}, 32'(en_sum), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_quot"}, 32'(quotient), 32'd0);
    chk({tag, "_rem"}, 32'(remainder), 32'd0);
    chk({tag, "_dz"}, 32'(div_zero), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("reset");

    run_div(16'd100, 16'd7, 0, 16'd0, 16'd0);
    run_div(16'hFFFF, 16'd1, 0, 16'd0, 16'd0);
    run_div(16'hFFFF, 16'h8001, 0, 16'd0, 16'd0);
    run_div(16'd1234, 16'd0, 0, 16'd0, 16'd0);
    run_div(16'd100, 16'd7, 5, 16'd9, 16'd3);

    // Abort mid-division with reset; no done pulse may appear
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk_all_zero("abort");
    tick();
    chk("abort_idle_done", 32'(done), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    run_div(16'd9, 16'd3, 0, 16'd0, 16'd0);

    // Start asserted together with reset: reset wins
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd5;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk_all_zero("rst_start");

    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      unique case (n % 4)
        0: rb = 16'($urandom);
        1: rb = 16'($urandom_range(1, 15));
        2: rb = 16'($urandom_range(0, 3));
        default: rb = 16'($urandom) | 16'h8000;
      endcase
      run_div(ra, rb, (n % 3 == 0) ? 3 + n % 10 : 0, 16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
